// File: rtl/cnt_share_arbiter.sv
// Round-robin arbiter that time-shares one terminal-count counter among REQ_NUM requesters.
// The winner's length is latched at grant; done/po_flag pulse once when the count reaches it.
module cnt_share_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int CNT_W   = 8,
  parameter int CNT_MAX = 100
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [REQ_NUM-1:0]       req,
  input  logic [REQ_NUM*CNT_W-1:0] req_len,
  output logic [REQ_NUM-1:0]       gnt,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_out,
  output logic [REQ_NUM-1:0]       done,
  output logic                     po_flag
);

  localparam int PTR_W = $clog2(REQ_NUM);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [CNT_W-1:0]   len_q, len_n;
  logic [CNT_W-1:0]   cnt_n;
  logic [REQ_NUM-1:0] gnt_n, done_n;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [CNT_W-1:0]   win_len;

  // First requesting index at or after ptr, wrapping; earliest offset wins
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = REQ_NUM - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= REQ_NUM) cand = cand - REQ_NUM;
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(cand);
      end
    end
    win_len = req_len[win_idx*CNT_W +: CNT_W];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      len_q   <= '0;
      cnt_out <= '0;
      gnt     <= '0;
      done    <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      len_q   <= len_n;
      cnt_out <= cnt_n;
      gnt     <= gnt_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    len_n   = len_q;
    cnt_n   = cnt_out;
    gnt_n   = gnt;
    done_n  = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          len_n   = (win_len == '0) ? CNT_W'(CNT_MAX) : win_len;
          gnt_n   = REQ_NUM'(1) << win_idx;
          cnt_n   = '0;
          owner_n = win_idx;
          ptr_n   = (win_idx == PTR_W'(REQ_NUM - 1)) ? '0 : win_idx + 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        // Abort beats completion: a dropped request never earns a done pulse
        if (!req[owner]) begin
          gnt_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt_out == len_q) begin
          gnt_n   = '0;
          done_n  = gnt;
          state_n = DONE;
        end else begin
          cnt_n = cnt_out + 1'b1;
        end
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = |gnt;
  assign po_flag = |done;

endmodule

// File: tb/tb_cnt_share_arbiter.sv
// Directed bench for cnt_share_arbiter: single, simultaneous, fairness, zero-length, abort and mid-run reset.
module tb_cnt_share_arbiter;

  localparam int REQ_NUM = 4;
  localparam int CNT_W   = 8;

  logic                     sys_clk = 1'b0;
  logic                     sys_rst;
  logic [REQ_NUM-1:0]       req;
  logic [REQ_NUM*CNT_W-1:0] req_len;
  logic [REQ_NUM-1:0]       gnt;
  logic                     busy;
  logic [CNT_W-1:0]         cnt_out;
  logic [REQ_NUM-1:0]       done;
  logic                     po_flag;

  int check_count = 0;
  int pass_count  = 0;

  cnt_share_arbiter #(.REQ_NUM(REQ_NUM), .CNT_W(CNT_W), .CNT_MAX(100)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .req_len (req_len),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_out (cnt_out),
    .done    (done),
    .po_flag (po_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  // Outputs are sampled 1ns after the rising edge; inputs change at the same moment
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [REQ_NUM-1:0] r, input logic [7:0] l3, input logic [7:0] l2,
                               input logic [7:0] l1, input logic [7:0] l0);
    req     = r;
    req_len = {l3, l2, l1, l0};
  endtask

  task automatic doReset();
    sys_rst = 1'b1;
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
    checkOutput({tag, "_cnt"}, 32'(cnt_out), 32'h0);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_po"}, 32'(po_flag), 32'h0);
  endtask

  initial begin
    doReset();
    checkIdle("reset");

    // Single request, length 5
    applyStimulus(4'b0001, 8'd0, 8'd0, 8'd0, 8'd5);
    tick();
    checkOutput("single_gnt", 32'(gnt), 32'h1);
    checkOutput("single_cnt0", 32'(cnt_out), 32'd0);
    for (int n = 1; n <= 5; n++) begin
      tick();
      checkOutput("single_cnt", 32'(cnt_out), 32'(n));
      checkOutput("single_gnt_hold", 32'(gnt), 32'h1);
      checkOutput("single_no_done", 32'(done), 32'h0);
    end
    tick();
    checkOutput("single_done", 32'(done), 32'h1);
    checkOutput("single_po", 32'(po_flag), 32'h1);
    checkOutput("single_gnt_low", 32'(gnt), 32'h0);
    checkOutput("single_cnt_hold", 32'(cnt_out), 32'd5);
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checkIdle("single_after");
    tick();
    checkIdle("single_idle");

    // Simultaneous requests 0 and 2 from reset
    doReset();
    applyStimulus(4'b0101, 8'd0, 8'd2, 8'd0, 8'd3);
    tick();
    checkOutput("sim_gnt0", 32'(gnt), 32'h1);
    for (int n = 1; n <= 3; n++) begin
      tick();
      checkOutput("sim_cnt_a", 32'(cnt_out), 32'(n));
    end
    tick();
    checkOutput("sim_done0", 32'(done), 32'h1);
    applyStimulus(4'b0100, 8'd0, 8'd2, 8'd0, 8'd3);
    tick();
    checkOutput("sim_gap", 32'(gnt), 32'h0);
    tick();
    checkOutput("sim_gnt2", 32'(gnt), 32'h4);
    checkOutput("sim_cnt_b0", 32'(cnt_out), 32'd0);
    tick();
    tick();
    checkOutput("sim_cnt_b2", 32'(cnt_out), 32'd2);
    tick();
    checkOutput("sim_done2", 32'(done), 32'h4);
    checkOutput("sim_po2", 32'(po_flag), 32'h1);
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checkIdle("sim_after");

    // Fairness: all four requesters with length 1
    doReset();
    applyStimulus(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1);
    tick();
    for (int g = 0; g < 6; g++) begin
      checkOutput("fair_gnt", 32'(gnt), 32'(1 << (g % 4)));
      tick();
      checkOutput("fair_cnt1", 32'(cnt_out), 32'd1);
      tick();
      checkOutput("fair_done", 32'(done), 32'(1 << (g % 4)));
      tick();
      checkOutput("fair_idle_gnt", 32'(gnt), 32'h0);
      tick();
    end
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);

    // Zero length falls back to 100
    doReset();
    applyStimulus(4'b0010, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checkOutput("zero_gnt", 32'(gnt), 32'h2);
    repeat (100) tick();
    checkOutput("zero_cnt100", 32'(cnt_out), 32'd100);
    checkOutput("zero_gnt_hold", 32'(gnt), 32'h2);
    checkOutput("zero_no_done", 32'(done), 32'h0);
    tick();
    checkOutput("zero_done", 32'(done), 32'h2);
    checkOutput("zero_po", 32'(po_flag), 32'h1);
    applyStimulus(4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    checkIdle("zero_after");

    // Abort of requester 3 at count 10, requester 0 pending
    doReset();
    applyStimulus(4'b1000, 8'd50, 8'd0, 8'd0, 8'd0);
    tick();
    checkOutput("abort_gnt3", 32'(gnt), 32'h8);
    repeat (10) tick();
    checkOutput("abort_cnt10", 32'(cnt_out), 32'd10);
    applyStimulus(4'b0001, 8'd50, 8'd0, 8'd0, 8'd4);
    tick();
    checkIdle("abort_drop");
    tick();
    checkOutput("abort_gnt0", 32'(gnt), 32'h1);
    checkOutput("abort_cnt0", 32'(cnt_out), 32'd0);

    // Reset mid-run; pointer must return to 0
    applyStimulus(4'b0100, 8'd0, 8'd20, 8'd0, 8'd0);
    tick();
    checkOutput("rst_abort_prev", 32'(gnt), 32'h0);
    tick();
    checkOutput("rst_gnt2", 32'(gnt), 32'h4);
    repeat (7) tick();
    checkOutput("rst_cnt7", 32'(cnt_out), 32'd7);
    sys_rst = 1'b1;
    tick();
    checkIdle("rst_mid");
    sys_rst = 1'b0;
    applyStimulus(4'b1111, 8'd2, 8'd2, 8'd2, 8'd2);
    tick();
    checkOutput("rst_regrant0", 32'(gnt), 32'h1);
    checkOutput("rst_busy", 32'(busy), 32'h1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/cnt_share_arbiter.md
# cnt_share_arbiter

Round-robin arbiter and sequencer that shares one terminal-count counter among REQ_NUM requesters. Each requester raises a request with its own count length; the block grants one requester at a time and runs the counter from 0 to that length. It pulses a per-requester done flag and the shared `po_flag` on terminal count. It sits between the control logic of several sub-blocks and the single shared timing resource.

## Interface
- `REQ_NUM`, 4: number of requesters, 2..8.
- `CNT_W`, 8: counter and length width.
- `CNT_MAX`, 100: length used when a requester supplies length 0; must be < 2^CNT_W.

- `sys_clk`  input  1  single clock; all logic on its rising edge.
- `sys_rst`  input  1  synchronous, active-high reset.
- `req`  input  REQ_NUM  level request per requester; held until done or dropped to abort.
- `req_len`  input  REQ_NUM*CNT_W  requester i's terminal count in bits [i*CNT_W +: CNT_W].
- `gnt`  output  REQ_NUM  one-hot grant; all-zero when no owner.
- `busy`  output  1  high while any grant is active (equals OR of `gnt`).
- `cnt_out`  output  CNT_W  current shared count value.
- `done`  output  REQ_NUM  one-cycle pulse to the owner at completion.
- `po_flag`  output  1  one-cycle pulse, equal to OR of `done`.

## Operation
- Reset values: `gnt`=0, `busy`=0, `cnt_out`=0, `done`=0, `po_flag`=0, state IDLE, round-robin pointer `ptr`=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any `req` bit is high, select the winner by searching from index `ptr` upward, wrapping at REQ_NUM-1 -> 0.
  - Latch the winner's `req_len` into `len_q`; `req_len` = 0 latches CNT_MAX.
  - Assert that winner's `gnt` bit, clear `cnt_out` to 0, set `ptr` = winner+1 (mod REQ_NUM), go to RUN.
  - With no request, stay in IDLE.
- RUN, priority order:
  - Owner's `req` low: abort. Clear `gnt` and `cnt_out`, go to IDLE. No `done`. `ptr` is not restored.
  - Else `cnt_out` == `len_q`: clear `gnt`, pulse `done[owner]` and `po_flag`, go to DONE. `cnt_out` holds `len_q`.
  - Else increment `cnt_out` by 1.
- DONE: one cycle. `done` and `po_flag` return to 0, `cnt_out` clears to 0, go to IDLE.
- Arbitration happens only in IDLE:
  - Requests arriving during RUN or DONE wait.
  - Changes to `req_len` after the grant cycle are ignored.
  - Non-owner request changes during RUN have no effect.
- A requester that keeps `req` high after its `done` is eligible again, but has lowest priority due to the pointer advance.
- Width rules: `cnt_out` is never incremented past `len_q` (max 2^CNT_W-1), so it never wraps. `ptr` is ceil(log2(REQ_NUM)) bits with explicit wrap to 0.
- `sys_rst` asserted in any state, mid-run included: next edge forces all reset values. No `done` is emitted for the interrupted run.

## Timing
- `req` high sampled in IDLE at edge k -> `gnt` high and `cnt_out`=0 after edge k.
- `cnt_out` = n after edge k+n, for n <= L = `len_q`.
- `done` and `po_flag` high for the single cycle after edge k+L+1, with `gnt` already low.
- State is DONE after edge k+L+1 and IDLE after edge k+L+2.
- The earliest next grant follows edge k+L+3. The full cycle from grant to next grant is L+3 clocks.
- Abort: owner `req` low sampled at edge j in RUN -> `gnt`=0 and `cnt_out`=0 after edge j. A new grant is possible after edge j+1.
- Every output is registered; there are no combinational input-to-output paths.

## Test plan
- Single request: `req`=0001, len0=5 -> `gnt`=0001 for 6 cycles while `cnt_out` steps 0..5. Then `done`=0001 and `po_flag`=1 for exactly one cycle, then `busy`=0.
- Simultaneous requests: `req`=0101, len0=3, len2=2 from reset.
  - Requester 0 is granted first and completes.
  - Requester 2 is granted 6 clocks after requester 0's grant and completes with `done`=0100.
- Fairness: all four `req` held high with len=1 each -> grant order 0,1,2,3,0,1, each grant spaced 4 clocks, and `done` follows the same order.
- Zero length: `req`=0010, len1=0 -> `cnt_out` counts to 100. `done`=0010 pulses 101 cycles after the grant, then the counter clears.
- Abort: requester 3 granted with len=50, `req[3]` dropped at `cnt_out`=10 -> `gnt`=0 and `cnt_out`=0 on the next cycle, no `done`, and pending requester 0 is granted two cycles later.
- Reset mid-run: `sys_rst` pulsed at `cnt_out`=7 -> all outputs 0 on the next cycle, `ptr`=0, and no `done` pulse. A later `req`=1111 grants requester 0 first.
